// File: rtl/gpi_rx_conditioner_if.sv
// gpi_rx_conditioner_if: pad, config and event signals of the GPI receive conditioner
interface gpi_rx_conditioner_if #(parameter int CNT_W = 8);
   logic             pad_di;
   logic             pad_ie;
   logic             pad_pu;
   logic             pad_pd;
   logic             cfg_en;
   logic [1:0]       cfg_pull;
   logic [CNT_W-1:0] cfg_db_len;
   logic [1:0]       cfg_edge_sel;
   logic             irq_clr;
   logic             data_o;
   logic             rise_o;
   logic             fall_o;
   logic             irq_o;
   modport slave (
      input  pad_di, cfg_en, cfg_pull, cfg_db_len, cfg_edge_sel, irq_clr,
      output pad_ie, pad_pu, pad_pd, data_o, rise_o, fall_o, irq_o
   );
   modport master (
      output pad_di, cfg_en, cfg_pull, cfg_db_len, cfg_edge_sel, irq_clr,
      input  pad_ie, pad_pu, pad_pd, data_o, rise_o, fall_o, irq_o
   );
endinterface

// File: rtl/gpi_rx_conditioner.sv
// gpi_rx_conditioner: GPI pad control, input synchronizer, stable-count debounce, edge detect and sticky irq
module gpi_rx_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input logic                  clk,
   input logic                  rst,
   gpi_rx_conditioner_if.slave  bus
);
   localparam logic [1:0] OFF      = 2'd0;
   localparam logic [1:0] SETTLE   = 2'd1;
   localparam logic [1:0] STABLE   = 2'd2;
   localparam logic [1:0] DEBOUNCE = 2'd3;

   logic [SYNC_STAGES-1:0] r_sync;
   logic [1:0]             r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_ie, r_pu, r_pd, r_data, r_rise, r_fall, r_irq;
   logic                   w_s, w_commit;

   assign w_s = r_sync[SYNC_STAGES-1];
   // a change commits once s has differed from data_o for cfg_db_len+1 samples
   assign w_commit = bus.cfg_en & (w_s ^ r_data) &
                     (((r_state == STABLE) & (bus.cfg_db_len == '0)) |
                      ((r_state == DEBOUNCE) & (r_cnt >= bus.cfg_db_len)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync  <= '0;
         r_state <= OFF;
         r_cnt   <= '0;
         r_ie    <= 1'b0;
         r_pu    <= 1'b0;
         r_pd    <= 1'b0;
         r_data  <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_irq   <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pad_di};
         r_ie   <= bus.cfg_en;
         r_pu   <= bus.cfg_en & (bus.cfg_pull == 2'b01);
         r_pd   <= bus.cfg_en & (bus.cfg_pull == 2'b10);
         r_rise <= w_commit & w_s;
         r_fall <= w_commit & ~w_s;
         r_irq  <= (r_rise & bus.cfg_edge_sel[0]) | (r_fall & bus.cfg_edge_sel[1]) | (r_irq & ~bus.irq_clr);
         if (!bus.cfg_en) begin
            r_state <= OFF;
            r_cnt   <= '0;
            r_data  <= 1'b0;
         end else if (w_commit) begin
            r_state <= STABLE;
            r_data  <= w_s;
         end else if (r_state == OFF) begin
            r_state <= SETTLE;
            r_cnt   <= '0;
         end else if (r_state == SETTLE) begin
            if (r_cnt == CNT_W'(SYNC_STAGES)) begin
               r_state <= STABLE;
               r_data  <= w_s;
            end else
               r_cnt <= r_cnt + 1'b1;
         end else if (r_state == STABLE) begin
            if (w_s != r_data) begin
               r_state <= DEBOUNCE;
               r_cnt   <= CNT_W'(1);
            end
         end else begin
            if (w_s == r_data)
               r_state <= STABLE;
            else
               r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign bus.pad_ie = r_ie;
   assign bus.pad_pu = r_pu;
   assign bus.pad_pd = r_pd;
   assign bus.data_o = r_data;
   assign bus.rise_o = r_rise;
   assign bus.fall_o = r_fall;
   assign bus.irq_o  = r_irq;
endmodule

// File: tb/tb_gpi_rx_conditioner.sv
// tb_gpi_rx_conditioner: directed self-checking bench for gpi_rx_conditioner (SYNC_STAGES=2, CNT_W=8)
module tb_gpi_rx_conditioner;
   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   gpi_rx_conditioner_if #(.CNT_W(8)) bus ();
   gpi_rx_conditioner #(.SYNC_STAGES(2), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] outs();
      return {1'b0, bus.pad_ie, bus.pad_pu, bus.pad_pd, bus.data_o, bus.rise_o, bus.fall_o, bus.irq_o};
   endfunction

   initial begin
      rst = 1'b1;
      bus.pad_di = 1'b0; bus.cfg_en = 1'b0; bus.cfg_pull = 2'b00;
      bus.cfg_db_len = 8'd0; bus.cfg_edge_sel = 2'b00; bus.irq_clr = 1'b0;
      step(2);
      chk("reset_outs", outs(), 8'h00);
      rst = 1'b0;
      step(1);
      // enable with pull-up, pad already high
      bus.pad_di = 1'b1; bus.cfg_pull = 2'b01; bus.cfg_db_len = 8'd3; bus.cfg_edge_sel = 2'b01; bus.cfg_en = 1'b1;
      step(1);
      chk("pad_ie", bus.pad_ie, 1); chk("pad_pu", bus.pad_pu, 1); chk("pad_pd", bus.pad_pd, 0);
      step(2);
      chk("settle_wait", bus.data_o, 0);
      step(1);
      chk("settle_data", bus.data_o, 1); chk("settle_norise", bus.rise_o, 0);
      step(1);
      chk("settle_noirq", bus.irq_o, 0);
      // fall with zero debounce; edge_sel=01 must ignore it
      bus.cfg_db_len = 8'd0; bus.pad_di = 1'b0;
      step(3);
      chk("fall0_data", bus.data_o, 0); chk("fall0_pulse", bus.fall_o, 1);
      step(1);
      chk("fall_nosel_irq", bus.irq_o, 0);
      // latency with db_len=3: commit on 6th edge
      bus.cfg_db_len = 8'd3; bus.pad_di = 1'b1;
      step(5);
      chk("lat_edge5_data", bus.data_o, 0); chk("lat_edge5_rise", bus.rise_o, 0);
      step(1);
      chk("lat_edge6_data", bus.data_o, 1); chk("lat_edge6_rise", bus.rise_o, 1);
      step(1);
      chk("lat_rise_width", bus.rise_o, 0); chk("lat_irq", bus.irq_o, 1);
      bus.irq_clr = 1'b1;
      step(1);
      bus.irq_clr = 1'b0;
      chk("clr_alone", bus.irq_o, 0);
      // zero debounce, fall-only interrupts
      bus.cfg_db_len = 8'd0; bus.cfg_edge_sel = 2'b10; bus.pad_di = 1'b0;
      step(2);
      chk("z_fall_edge2", bus.data_o, 1);
      step(1);
      chk("z_fall_edge3", bus.data_o, 0); chk("z_fall_pulse", bus.fall_o, 1);
      step(1);
      chk("z_fall_irq", bus.irq_o, 1);
      bus.irq_clr = 1'b1; bus.pad_di = 1'b1;
      step(1);
      bus.irq_clr = 1'b0;
      chk("z_clr", bus.irq_o, 0);
      step(2);
      chk("z_rise_data", bus.data_o, 1); chk("z_rise_pulse", bus.rise_o, 1);
      step(1);
      chk("z_rise_noirq", bus.irq_o, 0);
      bus.pad_di = 1'b0;
      step(3);
      chk("sw_fall_pulse", bus.fall_o, 1); chk("sw_irq_before", bus.irq_o, 0);
      bus.irq_clr = 1'b1;
      step(1);
      bus.irq_clr = 1'b0;
      chk("set_wins", bus.irq_o, 1);
      bus.irq_clr = 1'b1;
      step(1);
      bus.irq_clr = 1'b0;
      chk("clr_again", bus.irq_o, 0);
      // glitch of 4 cycles against db_len=5
      bus.cfg_db_len = 8'd5; bus.cfg_edge_sel = 2'b11; bus.pad_di = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk("glitch_hi", {bus.data_o, bus.rise_o, bus.fall_o, bus.irq_o}, 8'h0);
      end
      bus.pad_di = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         chk("glitch_lo", {bus.data_o, bus.rise_o, bus.fall_o, bus.irq_o}, 8'h0);
      end
      // back in STABLE: db_len=1 commits on the 4th edge
      bus.cfg_db_len = 8'd1; bus.pad_di = 1'b1;
      step(3);
      chk("post_glitch_e3", bus.data_o, 0);
      step(1);
      chk("post_glitch_e4", bus.data_o, 1); chk("post_glitch_rise", bus.rise_o, 1);
      step(1);
      chk("post_glitch_irq", bus.irq_o, 1);
      // asynchronous reset mid-debounce
      bus.cfg_db_len = 8'd10; bus.pad_di = 1'b0;
      step(4);
      #2 rst = 1'b1;
      #1 chk("async_reset", outs(), 8'h00);
      step(1);
      rst = 1'b0;
      // live lowering of cfg_db_len
      bus.cfg_pull = 2'b10;
      step(6);
      chk("pd_on", bus.pad_pd, 1); chk("pu_off", bus.pad_pu, 0); chk("live_base", bus.data_o, 0);
      bus.cfg_db_len = 8'd10; bus.pad_di = 1'b1;
      step(8);
      chk("live_cnt6", bus.data_o, 0);
      bus.cfg_db_len = 8'd2;
      step(1);
      chk("live_commit", bus.data_o, 1); chk("live_rise", bus.rise_o, 1);
      step(1);
      chk("live_irq", bus.irq_o, 1);
      // disable while high
      bus.cfg_en = 1'b0;
      step(1);
      chk("dis_data", bus.data_o, 0); chk("dis_nofall", bus.fall_o, 0);
      chk("dis_pads", {bus.pad_ie, bus.pad_pu, bus.pad_pd}, 8'h0); chk("dis_irq", bus.irq_o, 1);
      step(1);
      chk("dis_nofall2", bus.fall_o, 0); chk("dis_irq2", bus.irq_o, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
